regfile_operand_reader: RTL and testbench
=========================================

Name: regfile_operand_reader

Overview:
- Read-side companion to the register file's write path.
- Takes a decoded source-register pair, drives the register file read addresses and captures both operands into a single registered output stage.
- Forwards same-cycle writeback data so a read never returns a stale value, and refreshes held operands while downstream stalls.
- Sits between decode and execute in the pipelined CPU.

Parameters:
- DATA_W, 64, operand / register width
- ADDR_W, 5, register index width
- ZERO_REG, 31, index hard-wired to read as zero (XZR)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  source pair present
- in_ready  output  1  block can accept a pair this cycle
- in_rs1  input  ADDR_W  source register 1 index
- in_rs2  input  ADDR_W  source register 2 index
- rd_addr1  output  ADDR_W  register file read address, port 1
- rd_addr2  output  ADDR_W  register file read address, port 2
- rd_data1  input  DATA_W  register file read data, port 1 (combinational)
- rd_data2  input  DATA_W  register file read data, port 2 (combinational)
- wb_en  input  1  register file write enable this cycle
- wb_addr  input  ADDR_W  register file write index
- wb_data  input  DATA_W  register file write data
- out_valid  output  1  operand pair valid
- out_ready  input  1  consumer takes the pair this cycle
- out_rs1  output  ADDR_W  captured index 1
- out_rs2  output  ADDR_W  captured index 2
- out_op1  output  DATA_W  operand 1
- out_op2  output  DATA_W  operand 2

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_op1=out_op2=0, out_rs1=out_rs2=ZERO_REG. State is held until reset returns to 1. Reset mid-stall drops the held pair.
- rd_addr1=in_rs1 and rd_addr2=in_rs2 combinationally, regardless of in_valid.
- in_ready = ~out_valid | out_ready (combinational). No dependence on in_valid.
- Accept: in_valid & in_ready & ~flush. On the next edge the stage captures out_rs1/2 and the selected operands, and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- Operand select, per port N, at accept:
  - If rsN==ZERO_REG, the operand is 0, even when wb_en targets ZERO_REG.
  - Else if wb_en & wb_addr==rsN, the operand is wb_data (write-through bypass, since the register file commits only at the edge).
  - Else the operand is rd_dataN.
- Both ports may hit the same wb_addr; both then take wb_data.
- Hold: when out_valid & ~out_ready & ~flush, out_rs1/2 are unchanged. For each port N, if wb_en & wb_addr==out_rsN & out_rsN!=ZERO_REG, out_opN <= wb_data on that edge; otherwise it is unchanged.
- Drain: out_valid & out_ready & no accept -> out_valid=0 next cycle. Operand registers may keep stale values.
- Back-to-back: out_ready=1 with a new accept replaces the pair every cycle at full throughput.
- Flush has highest priority after reset. On the next edge out_valid=0 and any same-cycle accept is discarded. in_ready is not gated by flush.
- out_valid must not drop without out_ready or flush. out_rs1/2 and out_op1/2 are stable while out_valid & ~out_ready, except for hold-refresh updates.

Test Plan:
- Reset: hold reset=0 mid-stall with out_valid=1 -> out_valid=0, ops=0, out_rs=31 immediately (before the next edge). After release, first accept of rs1=2, rs2=3 with rd_data1=0xA, rd_data2=0xB -> next cycle out_valid=1, op1=0xA, op2=0xB.
- Bypass: accept rs1=5, rs2=5 with rd_data=0x11 and wb_en=1, wb_addr=5, wb_data=0x99 -> op1=op2=0x99.
- Zero register: rs1=31 with wb_en=1, wb_addr=31, wb_data=0xFF, rd_data1=0x77 -> op1=0.
- Stall refresh: capture rs1=7 (op1=0x1), then out_ready=0 for 3 cycles with wb_en=1, wb_addr=7, wb_data=0x42 in cycle 2 -> op1=0x1 then 0x42. in_ready=0 throughout. Pair released when out_ready=1.
- Throughput: 4 consecutive pairs with in_valid=1, out_ready=1 -> 4 consecutive out_valid cycles carrying the pairs in order.
- Flush: in_valid=1 and flush=1 with out_valid=1 -> next cycle out_valid=0 and the offered pair is not captured.

Source files
------------

// File: rtl/regfile_operand_reader.sv
// ---------------------------------------------------------------------------
// regfile_operand_reader
//
// Read side of the register file. It sits between decode and execute. It
// presents the decoded source indices to the register file read ports and
// captures both operands into one registered output stage. Writeback data
// from the same cycle is forwarded, so a captured operand is never stale. A
// held operand also follows writes to its register while downstream stalls.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   flush               synchronous pipeline flush (drops held and offered pair)
//   in_valid/in_ready   source pair handshake from decode
//   in_rs1/in_rs2       source register indices
//   rd_addr1/rd_addr2   register file read addresses (= in_rs1/in_rs2)
//   rd_data1/rd_data2   register file read data (combinational)
//   wb_en/wb_addr/wb_data  writeback port, committed by the register file
//                       at the rising edge
//   out_valid/out_ready operand pair handshake to execute
//   out_rs1/out_rs2     captured indices
//   out_op1/out_op2     captured operands
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holding valid keeps its payload stable until the transfer.
// Ready never depends on the same side's valid. out_valid falls only after a
// transfer or a flush. While out_valid & ~out_ready, the payload changes only
// through writeback refresh of the held operands.
// ---------------------------------------------------------------------------
module regfile_operand_reader #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rs1,
    output logic [ADDR_W-1:0] out_rs2,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic              accept;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [DATA_W-1:0] hold_op1;
    logic [DATA_W-1:0] hold_op2;

    assign rd_addr1 = in_rs1;
    assign rd_addr2 = in_rs2;

    // Flush does not gate in_ready. It only discards the accept below.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Capture-time select. The register file only commits wb_data at the
    // edge, so a same-cycle write to the source index is forwarded. The zero
    // register wins over the bypass because XZR is never writable.
    always_comb begin
        sel_op1 = rd_data1;
        sel_op2 = rd_data2;
        if (wb_en && (wb_addr == in_rs1)) sel_op1 = wb_data;
        if (wb_en && (wb_addr == in_rs2)) sel_op2 = wb_data;
        if (in_rs1 == ZR) sel_op1 = '0;
        if (in_rs2 == ZR) sel_op2 = '0;
    end

    // Stall-time refresh. A held operand tracks writes to its own register,
    // so it is still current when execute finally takes it.
    always_comb begin
        hold_op1 = out_op1;
        hold_op2 = out_op2;
        if (wb_en && (wb_addr == out_rs1) && (out_rs1 != ZR)) hold_op1 = wb_data;
        if (wb_en && (wb_addr == out_rs2) && (out_rs2 != ZR)) hold_op2 = wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_rs1   <= ZR;
            out_rs2   <= ZR;
            out_op1   <= '0;
            out_op2   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_rs1   <= in_rs1;
            out_rs2   <= in_rs2;
            out_op1   <= sel_op1;
            out_op2   <= sel_op2;
        end else if (out_valid && !out_ready) begin
            out_op1   <= hold_op1;
            out_op2   <= hold_op2;
        end else begin
            // Drain, or idle. The operand registers keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_operand_reader.sv
// ---------------------------------------------------------------------------
// Bench for regfile_operand_reader.
//
// The bench owns a 32-entry register file, regs[]. It drives rd_data from
// regs[] and commits each writeback to regs[] one cycle later, which is how a
// real register file behaves. The reference rule is simple: whenever the
// pair is valid, each operand equals the architectural value of its register
// after the current edge's write, and 0 for register 31. A queue of accepted
// index pairs is matched against each pair execute takes.
// ---------------------------------------------------------------------------
module tb_regfile_operand_reader;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam logic [AW-1:0] ZR = 5'd31;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_rs1, out_rs2;
    logic [DW-1:0] out_op1, out_op2;

    regfile_operand_reader #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(31)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rs1  (out_rs1),
        .out_rs2  (out_rs2),
        .out_op1  (out_op1),
        .out_op2  (out_op2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register file owned by the bench ----------------
    logic [DW-1:0] regs [32];

    // Architectural value of register r once this edge's write has landed.
    function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] r);
        if (r == ZR) return '0;
        if (wb_en && wb_addr == r) return wb_data;
        return regs[r];
    endfunction

    // ---------------- reference model ----------------
    logic          m_valid;
    logic [AW-1:0] m_rs1, m_rs2;
    logic [DW-1:0] m_op1, m_op2;
    logic [2*AW-1:0] exp_q[$];
    logic          m_take;

    assign m_take = in_valid && (!m_valid || out_ready) && !flush;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            exp_q.delete();
        end else if (flush) begin
            m_valid <= 1'b0;
            exp_q.delete();
        end else if (m_take) begin
            m_valid <= 1'b1;
            m_rs1   <= in_rs1;
            m_rs2   <= in_rs2;
            m_op1   <= arch_val(in_rs1);
            m_op2   <= arch_val(in_rs2);
            exp_q.push_back({in_rs1, in_rs2});
        end else if (m_valid && !out_ready) begin
            m_op1 <= arch_val(m_rs1);
            m_op2 <= arch_val(m_rs2);
        end else begin
            m_valid <= 1'b0;
        end
    end

    // ---------------- per-cycle compare (away from the rising edge) ----------------
    always @(negedge clk) begin
        logic [2*AW-1:0] front;
        #2;
        chk("valid", DW'(out_valid), DW'(m_valid));
        chk("in_ready", DW'(in_ready), DW'(!m_valid || out_ready));
        chk("rd_addr1", DW'(rd_addr1), DW'(in_rs1));
        chk("rd_addr2", DW'(rd_addr2), DW'(in_rs2));
        if (m_valid) begin
            chk("rs1", DW'(out_rs1), DW'(m_rs1));
            chk("rs2", DW'(out_rs2), DW'(m_rs2));
            chk("op1", out_op1, m_op1);
            chk("op2", out_op2, m_op2);
        end
        if (reset && m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", DW'(1), DW'(0));
            end else begin
                front = exp_q.pop_front();
                chk("sb_pair", DW'({out_rs1, out_rs2}), DW'(front));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic ordy, input logic fl);
        @(negedge clk);
        if (wb_en) regs[wb_addr] = wb_data;  // register file commit of last cycle's write
        in_valid  = v;
        in_rs1    = r1;
        in_rs2    = r2;
        rd_data1  = regs[r1];
        rd_data2  = regs[r2];
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, '0, ordy, 1'b0);
    endtask

    // Observe the result of the most recent step.
    task automatic look();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
        rd_data1 = '0; rd_data2 = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};

        repeat (3) @(negedge clk);
        chk("por_valid", DW'(out_valid), DW'(0));
        chk("por_rs1", DW'(out_rs1), DW'(31));
        reset = 1'b1;
        idle(1'b1);

        // Reset mid-stall drops the held pair right away.
        step(1'b1, 5'd8, 5'd9, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        idle(1'b0);
        look();
        chk("stall_valid", DW'(out_valid), DW'(1));
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_op2", out_op2, 64'd0);
        chk("rst_rs1", DW'(out_rs1), DW'(31));
        chk("rst_rs2", DW'(out_rs2), DW'(31));
        @(negedge clk);
        reset = 1'b1;

        // First accept after reset.
        regs[2] = 64'hA; regs[3] = 64'hB;
        step(1'b1, 5'd2, 5'd3, 1'b0, 5'd0, '0, 1'b1, 1'b0);
        look();
        chk("first_valid", DW'(out_valid), DW'(1));
        chk("first_op1", out_op1, 64'hA);
        chk("first_op2", out_op2, 64'hB);

        // Both ports bypass the same writeback.
        regs[5] = 64'h11;
        step(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 64'h99, 1'b1, 1'b0);
        look();
        chk("byp_op1", out_op1, 64'h99);
        chk("byp_op2", out_op2, 64'h99);

        // Zero register ignores both read data and a write aimed at it.
        regs[31] = 64'h77;
        step(1'b1, 5'd31, 5'd4, 1'b1, 5'd31, 64'hFF, 1'b1, 1'b0);
        look();
        chk("zr_op1", out_op1, 64'h0);

        // Stall refresh.
        regs[7] = 64'h1;
        step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b1, 1'b0);
        look();
        chk("hold_cap", out_op1, 64'h1);
        step(1'b1, 5'd12, 5'd13, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        look();
        chk("hold_c1_op1", out_op1, 64'h1);
        chk("hold_c1_rdy", DW'(in_ready), DW'(0));
        step(1'b1, 5'd12, 5'd13, 1'b1, 5'd7, 64'h42, 1'b0, 1'b0);
        look();
        chk("hold_c2_op1", out_op1, 64'h42);
        chk("hold_c2_rs1", DW'(out_rs1), DW'(7));
        step(1'b1, 5'd12, 5'd13, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        look();
        chk("hold_c3_op1", out_op1, 64'h42);
        chk("hold_c3_rdy", DW'(in_ready), DW'(0));
        idle(1'b1);
        look();
        chk("release_valid", DW'(out_valid), DW'(0));

        // Full throughput.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 5'(10 + k), 5'(20 + k), 1'b0, 5'd0, '0, 1'b1, 1'b0);
            look();
            chk("tp_valid", DW'(out_valid), DW'(1));
            chk("tp_rs1", DW'(out_rs1), DW'(10 + k));
        end
        idle(1'b1);

        // Flush discards both the held pair and the offered pair.
        step(1'b1, 5'd14, 5'd15, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        step(1'b1, 5'd16, 5'd17, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        look();
        chk("flush_valid", DW'(out_valid), DW'(0));
        idle(1'b1);
        look();
        chk("flush_after", DW'(out_valid), DW'(0));

        // Random traffic, with writes steered toward live indices.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] r1, r2, wa;
            r1 = 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       wa = r1;
                1:       wa = out_rs1;
                2:       wa = 5'($urandom_range(0, 31));
                default: wa = 5'($urandom_range(28, 31));
            endcase
            step(1'($urandom_range(0, 3) != 0), r1, r2,
                 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
